// File: rtl/repeater_chk_pkg.sv
// Shared types and helpers for the repeater protocol checker.
// Error codes are ordered so that a lower code wins when several checks fire on one channel.
package repeater_chk_pkg;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_QUAL  = 3'd1,
    ERR_MASK  = 3'd2,
    ERR_HOLD  = 3'd3,
    ERR_DRAIN = 3'd4,
    ERR_STALL = 3'd5
  } err_code_e;

  localparam int unsigned MAX_CH = 8;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  function automatic logic [2:0] lsb_select(input logic [MAX_CH-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/repeater_chk_lane.sv
// One monitored repeater channel: previous-beat registers, stall counter and the
// five per-channel checks, reduced to a single winning error code.
module repeater_chk_lane
  import repeater_chk_pkg::*;
#(
  parameter int unsigned MASK_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              full_i,
  input  logic              qual_i,
  input  logic [MASK_W-1:0] mask_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              deq_fire_i,
  output logic              err_o,
  output logic [2:0]        code_o
);

  localparam int unsigned     CW        = idx_w(TIMEOUT);
  localparam logic [CW-1:0]   STALL_MAX = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic            STALL_EN  = (TIMEOUT != 0);

  logic              prev_full_q;
  logic              prev_deq_q;
  logic [MASK_W-1:0] prev_mask_q;
  logic [DATA_W-1:0] prev_data_q;
  logic [CW-1:0]     stall_cnt_q, stall_cnt_d;
  logic              stall_fired_q, stall_fired_d;

  logic      qual_hit_s, mask_hit_s, hold_hit_s, drain_hit_s, stall_hit_s;
  err_code_e code_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_full_q   <= 1'b0;
      prev_deq_q    <= 1'b0;
      prev_mask_q   <= '0;
      prev_data_q   <= '0;
      stall_cnt_q   <= '0;
      stall_fired_q <= 1'b0;
    end else begin
      prev_full_q   <= full_i;
      prev_deq_q    <= deq_fire_i;
      prev_mask_q   <= mask_i;
      prev_data_q   <= data_i;
      stall_cnt_q   <= stall_cnt_d;
      stall_fired_q <= stall_fired_d;
    end
  end

  // The counter saturates and the fired flag keeps a stall episode to a single report.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    stall_fired_d = stall_fired_q;
    if (!full_i || deq_fire_i) begin
      stall_cnt_d   = '0;
      stall_fired_d = 1'b0;
    end else begin
      if (stall_cnt_q != STALL_MAX) begin
        stall_cnt_d = stall_cnt_q + CW'(1'b1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (stall_hit_s) begin
        stall_fired_d = 1'b1;
      end else begin
        stall_fired_d = stall_fired_q;
      end
    end
  end

  always_comb begin
    qual_hit_s  = full_i & ~qual_i;
    mask_hit_s  = full_i & (mask_i != {MASK_W{1'b1}});
    hold_hit_s  = prev_full_q & full_i & ~prev_deq_q &
                  ((data_i != prev_data_q) | (mask_i != prev_mask_q));
    drain_hit_s = prev_full_q & ~full_i & ~prev_deq_q;
    stall_hit_s = STALL_EN & full_i & ~deq_fire_i &
                  (stall_cnt_q == STALL_MAX) & ~stall_fired_q;
  end

  always_comb begin
    code_s = ERR_NONE;
    if (qual_hit_s) begin
      code_s = ERR_QUAL;
    end else if (mask_hit_s) begin
      code_s = ERR_MASK;
    end else if (hold_hit_s) begin
      code_s = ERR_HOLD;
    end else if (drain_hit_s) begin
      code_s = ERR_DRAIN;
    end else if (stall_hit_s) begin
      code_s = ERR_STALL;
    end else begin
      code_s = ERR_NONE;
    end
  end

  assign code_o = code_s;
  assign err_o  = (code_s != ERR_NONE);

endmodule

// File: rtl/repeater_protocol_checker.sv
// Protocol checker over NCH repeater channels: per-channel lanes feed a first-error
// capture register, a saturating error counter and a registered per-channel strobe.
module repeater_protocol_checker
  import repeater_chk_pkg::*;
#(
  parameter int unsigned NCH      = 2,
  parameter int unsigned MASK_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned CNT_W    = 8,
  parameter bit          FATAL_EN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NCH-1:0]        full,
  input  logic [NCH-1:0]        qual,
  input  logic [NCH*MASK_W-1:0] mask,
  input  logic [NCH*DATA_W-1:0] data,
  input  logic [NCH-1:0]        deq_fire,
  input  logic                  clr,
  output logic                  err_any,
  output logic [2:0]            err_chan,
  output logic [2:0]            err_code,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [NCH-1:0]        err_pulse
);

  localparam int unsigned    SW       = CNT_W + 4;
  localparam logic [SW-1:0]  CNT_SAT  = {{4{1'b0}}, {CNT_W{1'b1}}};

  logic [NCH-1:0]    lane_err_s;
  logic [2:0]        lane_code_s [NCH];
  logic [MAX_CH-1:0] err_vec_s;
  logic [2:0]        win_chan_s;
  logic [2:0]        win_code_s;
  logic [3:0]        pop_s;
  logic              new_err_s;
  logic              keep_s;
  logic [CNT_W-1:0]  cnt_base_s;
  logic [SW-1:0]     sum_s;

  logic             err_any_q, err_any_d;
  logic [2:0]       err_chan_q, err_chan_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [NCH-1:0]   err_pulse_q;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    repeater_chk_lane #(
      .MASK_W (MASK_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
    ) u_lane (
      .clock     (clock),
      .reset_n   (reset_n),
      .full_i    (full[c]),
      .qual_i    (qual[c]),
      .mask_i    (mask[c*MASK_W +: MASK_W]),
      .data_i    (data[c*DATA_W +: DATA_W]),
      .deq_fire_i(deq_fire[c]),
      .err_o     (lane_err_s[c]),
      .code_o    (lane_code_s[c])
    );
  end

  always_comb begin
    err_vec_s  = MAX_CH'(lane_err_s);
    win_chan_s = lsb_select(err_vec_s);
    new_err_s  = |lane_err_s;
    win_code_s = 3'd0;
    pop_s      = 4'd0;
    for (int c = 0; c < NCH; c++) begin
      pop_s = pop_s + 4'(lane_err_s[c]);
      if (win_chan_s == 3'(c)) begin
        win_code_s = lane_code_s[c];
      end else begin
        win_code_s = win_code_s;
      end
    end
  end

  // A clear in the same cycle as an error wipes old state, then the new error is taken fresh.
  always_comb begin
    err_any_d  = err_any_q;
    err_chan_d = err_chan_q;
    err_code_d = err_code_q;
    cnt_base_s = err_cnt_q;
    keep_s     = err_any_q & ~clr;
    if (clr) begin
      err_any_d  = 1'b0;
      err_chan_d = 3'd0;
      err_code_d = 3'd0;
      cnt_base_s = '0;
    end else begin
      cnt_base_s = err_cnt_q;
    end
    if (new_err_s && !keep_s) begin
      err_any_d  = 1'b1;
      err_chan_d = win_chan_s;
      err_code_d = win_code_s;
    end else begin
      err_any_d  = err_any_d;
    end
    sum_s = SW'(cnt_base_s) + SW'(pop_s);
    if (sum_s > CNT_SAT) begin
      err_cnt_d = {CNT_W{1'b1}};
    end else begin
      err_cnt_d = sum_s[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_any_q   <= 1'b0;
      err_chan_q  <= 3'd0;
      err_code_q  <= 3'd0;
      err_cnt_q   <= '0;
      err_pulse_q <= '0;
    end else begin
      err_any_q   <= err_any_d;
      err_chan_q  <= err_chan_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= lane_err_s;
    end
  end

  assign err_any   = err_any_q;
  assign err_chan  = err_chan_q;
  assign err_code  = err_code_q;
  assign err_cnt   = err_cnt_q;
  assign err_pulse = err_pulse_q;

`ifndef SYNTHESIS
`ifndef PRINTF_COND
`define PRINTF_COND 1'b1
`endif
`ifndef STOP_COND
`define STOP_COND 1'b1
`endif
  logic print_cond_s;
  logic stop_cond_s;
  assign print_cond_s = `PRINTF_COND;
  assign stop_cond_s  = `STOP_COND;

  // Simulation-only abort naming the lowest erroring channel and its code.
  always @(posedge clock) begin
    if (FATAL_EN && reset_n && new_err_s && print_cond_s && stop_cond_s) begin
      $fatal(1, "repeater_protocol_checker: channel %0d code %0d", win_chan_s, win_code_s);
    end
  end
`endif

endmodule

// File: tb/tb_repeater_protocol_checker.sv
// Directed bench for repeater_protocol_checker with hand-computed expectations.
module tb_repeater_protocol_checker;

  logic        clock;
  logic        reset_n;
  logic [1:0]  full;
  logic [1:0]  qual;
  logic [15:0] mask;
  logic [63:0] data;
  logic [1:0]  deq_fire;
  logic        clr;
  logic        err_any;
  logic [2:0]  err_chan;
  logic [2:0]  err_code;
  logic [1:0]  err_cnt;
  logic [1:0]  err_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  repeater_protocol_checker #(
    .NCH     (2),
    .MASK_W  (8),
    .DATA_W  (32),
    .TIMEOUT (16),
    .CNT_W   (2),
    .FATAL_EN(1'b0)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .full     (full),
    .qual     (qual),
    .mask     (mask),
    .data     (data),
    .deq_fire (deq_fire),
    .clr      (clr),
    .err_any  (err_any),
    .err_chan (err_chan),
    .err_code (err_code),
    .err_cnt  (err_cnt),
    .err_pulse(err_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic any, input logic [2:0] chan,
                             input logic [2:0] code, input logic [1:0] cnt, input logic [1:0] pulse);
    check_val({tag, ".any"},   32'(err_any),   32'(any));
    check_val({tag, ".chan"},  32'(err_chan),  32'(chan));
    check_val({tag, ".code"},  32'(err_code),  32'(code));
    check_val({tag, ".cnt"},   32'(err_cnt),   32'(cnt));
    check_val({tag, ".pulse"}, 32'(err_pulse), 32'(pulse));
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    full     = 2'b00;
    qual     = 2'b00;
    mask     = 16'h0000;
    data     = 64'h0;
    deq_fire = 2'b00;
    clr      = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (3) cyc();
    check_state("reset", 1'b0, 3'd0, 3'd0, 2'd0, 2'b00);
    reset_n = 1'b1;
    cyc();

    // Clean transfer on ch0: hold a stable beat, then dequeue before dropping full.
    full = 2'b01; qual = 2'b11; mask = 16'hffff; data = 64'h0000_0000_a5a5_a5a5;
    repeat (5) cyc();
    deq_fire = 2'b01;
    cyc();
    idle();
    cyc(); cyc();
    check_state("clean", 1'b0, 3'd0, 3'd0, 2'd0, 2'b00);

    // Qualifier missing on ch1 while full.
    full = 2'b10; qual = 2'b00; mask = 16'hffff; deq_fire = 2'b10;
    cyc();
    check_state("qual", 1'b1, 3'd1, 3'd1, 2'd1, 2'b10);
    idle();
    cyc();
    check_state("qual_after", 1'b1, 3'd1, 3'd1, 2'd1, 2'b00);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check_state("clr", 1'b0, 3'd0, 3'd0, 2'd0, 2'b00);

    // Partial mask on both channels in the same cycle.
    full = 2'b11; qual = 2'b11; mask = 16'h7f7f; deq_fire = 2'b11;
    cyc();
    check_state("mask2", 1'b1, 3'd0, 3'd2, 2'd2, 2'b11);
    idle();
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;

    // Beat changes while held, then full drops with no dequeue.
    full = 2'b01; qual = 2'b01; mask = 16'hffff; data = 64'h0;
    cyc();
    data = 64'h1;
    cyc();
    check_state("hold", 1'b1, 3'd0, 3'd3, 2'd1, 2'b01);
    full = 2'b00;
    cyc();
    check_state("drain_kept", 1'b1, 3'd0, 3'd3, 2'd2, 2'b01);
    idle();
    cyc();
    check_val("drain_quiet.pulse", 32'(err_pulse), 32'd0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;

    full = 2'b01; qual = 2'b01; mask = 16'hffff; data = 64'h0;
    cyc();
    full = 2'b00;
    cyc();
    check_state("drain", 1'b1, 3'd0, 3'd4, 2'd1, 2'b01);
    idle();
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;

    // Stall: ch0 full for 20 cycles, exactly one report on the 16th edge.
    full = 2'b01; qual = 2'b01; mask = 16'hffff; data = 64'h0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      check_val($sformatf("stall_pulse%0d", k), 32'(err_pulse), (k == 15) ? 32'd1 : 32'd0);
    end
    check_state("stall", 1'b1, 3'd0, 3'd5, 2'd1, 2'b00);
    deq_fire = 2'b01;
    cyc();
    idle();
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;

    // Five error events against a 2-bit counter.
    full = 2'b11; qual = 2'b00; mask = 16'hffff; deq_fire = 2'b11;
    cyc();
    check_state("sat1", 1'b1, 3'd0, 3'd1, 2'd2, 2'b11);
    idle();
    cyc();
    full = 2'b11; qual = 2'b00; mask = 16'hffff; deq_fire = 2'b11;
    cyc();
    check_val("sat2.cnt", 32'(err_cnt), 32'd3);
    idle();
    cyc();
    full = 2'b01; qual = 2'b00; mask = 16'hffff; deq_fire = 2'b01;
    cyc();
    check_val("sat3.cnt", 32'(err_cnt), 32'd3);
    idle();
    cyc();

    // Clear coinciding with a fresh error on ch1.
    clr = 1'b1; full = 2'b10; qual = 2'b00; mask = 16'hffff; deq_fire = 2'b10;
    cyc();
    check_state("clr_err", 1'b1, 3'd1, 3'd1, 2'd1, 2'b10);
    idle();
    cyc();

    // Reset in the middle of a stall, with the beat changing on the first cycle after release.
    full = 2'b01; qual = 2'b01; mask = 16'hffff; data = 64'h5;
    repeat (10) cyc();
    reset_n = 1'b0;
    #1;
    check_state("mid_reset", 1'b0, 3'd0, 3'd0, 2'd0, 2'b00);
    cyc(); cyc();
    reset_n = 1'b1;
    data = 64'h6;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check_val($sformatf("post_reset%0d.pulse", k), 32'(err_pulse), 32'd0);
    end
    check_val("post_reset.any", 32'(err_any), 32'd0);
    deq_fire = 2'b01;
    cyc();
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/repeater_protocol_checker.md
Name: repeater_protocol_checker

Overview:
- Synthesizable, parametrised protocol checker for up to NCH TileLink-style repeater channels.
- Successor to the simulation-only repeater assertion; keeps the two combinational checks and adds sequential checks.
- The two combinational checks are: a full repeater must present a qualifying strobe, and its mask must be all-ones.
- The sequential checks are: hold-stability, illegal drain, and a stall timeout.
- Errors latch into a first-error capture register and a saturating counter, readable by the debug/test harness; in simulation an optional $fatal still fires.

Parameters:
NCH, 2, number of monitored repeater channels (1..8)
MASK_W, 8, width of each channel's byte mask
DATA_W, 32, width of the repeated payload checked for stability
TIMEOUT, 1024, max consecutive full cycles without dequeue before a stall error; 0 disables the check
CNT_W, 8, error counter width
FATAL_EN, 1, when 1 and not SYNTHESIS, $fatal on any new error

Ports:
clock  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
full  in  NCH  per-channel repeater "holding saved beat" flag
qual  in  NCH  per-channel qualifier that must be high while full
mask  in  NCH*MASK_W  per-channel mask of the presented beat
data  in  NCH*DATA_W  per-channel presented payload
deq_fire  in  NCH  per-channel dequeue handshake (valid&ready)
clr  in  1  synchronous clear of capture and counter
err_any  out  1  sticky: at least one error since reset/clr
err_chan  out  3  channel of first captured error
err_code  out  3  code of first captured error
err_cnt  out  CNT_W  saturating count of error events
err_pulse  out  NCH  one-cycle per-channel error strobe (registered)

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0; per-channel prev_full, prev_mask, prev_data and stall counters cleared.
- Checks evaluated per channel every cycle, only when reset_n=1. Priority when several fire on one channel: lowest code wins.
  - Code 1 QUAL: full & ~qual.
  - Code 2 MASK: full & (mask != all-ones).
  - Code 3 HOLD: prev_full & full & ~prev_deq & (data != prev_data or mask != prev_mask). The saved beat must stay stable until dequeued.
  - Code 4 DRAIN: prev_full & ~full & ~prev_deq. Full is only allowed to drop after a dequeue.
  - Code 5 STALL: stall_cnt reaches TIMEOUT-1 while full & ~deq_fire. Fires once per stall episode, and the counter then holds.
- prev_* registers sample each cycle; prev_deq = registered deq_fire.
- Stall counter:
  - Cleared when ~full or deq_fire.
  - Otherwise increments, saturating at TIMEOUT-1.
  - Width is clog2(TIMEOUT).
- err_pulse[c]: registered OR of channel c's checks; latency 1 cycle after the violating cycle.
- Capture:
  - On the first error cycle when err_any=0: latch err_chan = lowest-index channel with an error, and err_code = its winning code.
  - Set err_any. Later errors do not overwrite.
  - Outputs valid the cycle after the violation.
- err_cnt: adds popcount(err_pulse inputs) per cycle and saturates at 2^CNT_W-1; it never wraps.
- clr:
  - Zeroes err_any, err_chan, err_code and err_cnt on the next edge.
  - If an error occurs in the same cycle as clr, clr wins for the existing state. The new error is then captured fresh with err_any=1 and err_cnt = that cycle's popcount.
- Reset asserted mid-stall clears counters immediately. The first cycle after deassertion has prev_full=0, so HOLD and DRAIN cannot fire.
- Simulation: with FATAL_EN, a new error prints channel and code, then calls $fatal, guarded by `ifndef SYNTHESIS and PRINTF_COND/STOP_COND.

Decomposition:
- Package repeater_chk_pkg holds:
  - the error code enum (NONE=0, QUAL, MASK, HOLD, DRAIN, STALL);
  - the channel-index width function;
  - an lsb-priority-select function.
- Sub-module repeater_chk_lane: per-channel checks, prev registers and stall counter; emits err and code.
- Top instantiates NCH lanes (generate), arbitrates capture and counts.

Test Plan:
- Single channel holds full=1, qual=1, mask=8'hff, data stable, then deq_fire -> no errors; err_any=0, err_cnt=0.
- Ch1 drives full=1, qual=0 at cycle 10 -> err_pulse=2'b10 at cycle 11; err_chan=1, err_code=1, err_cnt=1.
- Ch0 and ch1 both drive full=1, mask=8'h7f in one cycle -> err_chan=0, err_code=2, err_cnt=2.
- Ch0 full, data changes 32'h0 -> 32'h1 with no deq -> code 3. A second run drops full with no deq -> code 4, capture unchanged if already set.
- TIMEOUT=16, ch0 full for 20 cycles without deq -> exactly one STALL pulse, at cycle 16 after full rises; err_cnt increments by 1.
- CNT_W=2, 5 error events -> err_cnt saturates at 3. Then clr -> all zero. Then reset_n low mid-stall -> no spurious error after release.
